routine_sequencer: RTL and testbench

ROUTINE_SEQUENCER -- requirements
Module: routine_sequencer

---
 rtl/routine_sequencer.sv | 156 +++++++++++++++
 tb/tb_routine_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/routine_sequencer.sv
// routine_sequencer: selects one of four display routines, steps them with a
// divided tick, and inserts a blanked gap on every change of routine. The
// advance comes from a pushbutton edge or, in auto mode, from a dwell timer.
module routine_sequencer #(
  parameter int TICK_DIV    = 25000000,
  parameter int DWELL_TICKS = 64,
  parameter int BLANK_TICKS = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Next,
  input  logic        Auto,
  input  logic [45:0] RoutineBus0,
  input  logic [45:0] RoutineBus1,
  input  logic [45:0] RoutineBus2,
  input  logic [45:0] RoutineBus3,
  output logic [3:0]  RoutineRun,
  output logic        RoutineTick,
  output logic [1:0]  Active,
  output logic [45:0] OutputBus
);

  localparam logic [25:0] LP_PRESC_LAST    = 26'(TICK_DIV - 1);
  localparam logic [7:0]  LP_DWELL_LAST    = 8'(DWELL_TICKS - 1);
  localparam logic [3:0]  LP_BLANK_LAST    = 4'(BLANK_TICKS - 1);
  // LEDs off (active-high), all seven-segment digits dark (active-low)
  localparam logic [45:0] LP_BLANK_PATTERN = {18'h00000, 28'hFFFFFFF};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  logic [25:0] r_presc;
  logic        r_tick;
  logic        r_next_prev;
  state_t      r_state;
  logic [1:0]  r_active;
  logic [7:0]  r_dwell;
  logic [3:0]  r_blank;
  logic [3:0]  r_run;
  logic [45:0] r_out;

  logic        w_next_edge;
  logic        w_expire;
  logic        w_advance;
  logic [45:0] w_sel_bus;

  assign w_next_edge = Next & ~r_next_prev;
  assign w_expire    = r_tick & Auto & (r_dwell == LP_DWELL_LAST);
  // a button edge and a dwell expiry on the same cycle still give one advance
  assign w_advance   = w_next_edge | w_expire;

  assign RoutineRun  = r_run;
  assign RoutineTick = r_tick;
  assign Active      = r_active;
  assign OutputBus   = r_out;

  // Free-running prescaler; the tick register mirrors "counter at last value"
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_presc <= 26'd0;
      r_tick  <= 1'b0;
    end else if (r_presc == LP_PRESC_LAST) begin
      r_presc <= 26'd0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= r_presc + 26'd1;
      r_tick  <= ((r_presc + 26'd1) == LP_PRESC_LAST);
    end
  end

  // Previous button level; resets high so a button held through reset is not an edge
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_next_prev <= 1'b1;
    end else begin
      r_next_prev <= Next;
    end
  end

  // Routine output select for the currently active routine
  always_comb begin
    w_sel_bus = RoutineBus0;
    case (r_active)
      2'd0:    w_sel_bus = RoutineBus0;
      2'd1:    w_sel_bus = RoutineBus1;
      2'd2:    w_sel_bus = RoutineBus2;
      2'd3:    w_sel_bus = RoutineBus3;
      default: w_sel_bus = RoutineBus0;
    endcase
  end

  // RUN/BLANK sequencer with dwell and blank tick counters and registered run enables
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_RUN;
      r_active <= 2'd0;
      r_dwell  <= 8'd0;
      r_blank  <= 4'd0;
      r_run    <= 4'b0000;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_advance) begin
            r_state  <= ST_BLANK;
            r_active <= r_active + 2'd1;
            r_dwell  <= 8'd0;
            r_blank  <= 4'd0;
            r_run    <= 4'b0000;
          end else begin
            if (!Auto) begin
              r_dwell <= 8'd0;
            end else if (r_tick) begin
              r_dwell <= r_dwell + 8'd1;
            end else begin
              r_dwell <= r_dwell;
            end
            r_run <= 4'b0001 << r_active;
          end
        end
        ST_BLANK: begin
          // button edges and dwell expiry are deliberately not looked at here
          if (r_tick && (r_blank == LP_BLANK_LAST)) begin
            r_state <= ST_RUN;
            r_dwell <= 8'd0;
            r_run   <= 4'b0001 << r_active;
          end else begin
            if (r_tick) begin
              r_blank <= r_blank + 4'd1;
            end else begin
              r_blank <= r_blank;
            end
            r_run <= 4'b0000;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_run   <= 4'b0000;
        end
      endcase
    end
  end

  // Registered board output: selected routine in RUN, dark pattern otherwise
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_out <= LP_BLANK_PATTERN;
    end else if (r_state == ST_RUN) begin
      r_out <= w_sel_bus;
    end else begin
      r_out <= LP_BLANK_PATTERN;
    end
  end

endmodule

// File: tb/tb_routine_sequencer.sv
// Self-checking bench for routine_sequencer with small timing parameters.
module tb_routine_sequencer;

  localparam int TD = 4;
  localparam int DW = 3;
  localparam int BT = 2;
  localparam logic [45:0] BLANK_PAT = {18'h00000, 28'hFFFFFFF};

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Next  = 1'b0;
  logic        Auto  = 1'b0;
  logic [45:0] bus [0:3];
  logic [3:0]  RoutineRun;
  logic        RoutineTick;
  logic [1:0]  Active;
  logic [45:0] OutputBus;

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset, and "ticks remaining" countdowns
  int          m_cyc       = 0;
  bit          m_blanking  = 1'b0;
  logic [1:0]  m_active    = 2'd0;
  int          m_dwell_left = DW;
  int          m_blank_left = BT;
  bit          m_prev      = 1'b1;
  logic [45:0] m_out       = BLANK_PAT;
  logic [3:0]  m_run       = 4'b0000;
  bit          m_tick      = 1'b0;

  routine_sequencer #(.TICK_DIV(TD), .DWELL_TICKS(DW), .BLANK_TICKS(BT)) dut (
    .Clock(Clock), .Reset(Reset), .Next(Next), .Auto(Auto),
    .RoutineBus0(bus[0]), .RoutineBus1(bus[1]), .RoutineBus2(bus[2]), .RoutineBus3(bus[3]),
    .RoutineRun(RoutineRun), .RoutineTick(RoutineTick), .Active(Active), .OutputBus(OutputBus)
  );

  always #5 Clock = ~Clock;

  task automatic model_update();
    bit tick_now;
    bit edge_s;
    if (Reset) begin
      m_cyc = 0; m_blanking = 1'b0; m_active = 2'd0;
      m_dwell_left = DW; m_blank_left = BT; m_prev = 1'b1;
      m_out = BLANK_PAT; m_run = 4'b0000;
    end else begin
      tick_now = ((m_cyc % TD) == TD - 1);
      m_cyc = m_cyc + 1;
      m_out = m_blanking ? BLANK_PAT : bus[m_active];
      edge_s = Next && !m_prev;
      m_prev = Next;
      if (!m_blanking) begin
        if (edge_s || (tick_now && Auto && m_dwell_left == 1)) begin
          m_blanking = 1'b1;
          m_active = (m_active == 2'd3) ? 2'd0 : m_active + 2'd1;
          m_blank_left = BT;
          m_dwell_left = DW;
        end else if (!Auto) begin
          m_dwell_left = DW;
        end else if (tick_now) begin
          m_dwell_left = m_dwell_left - 1;
        end
      end else if (tick_now) begin
        if (m_blank_left == 1) begin
          m_blanking = 1'b0;
          m_dwell_left = DW;
        end else begin
          m_blank_left = m_blank_left - 1;
        end
      end
      m_run = m_blanking ? 4'b0000 : (4'b0001 << m_active);
    end
    m_tick = !Reset && ((m_cyc % TD) == TD - 1);
  endtask

  task automatic step();
    for (int i = 0; i < 4; i++) bus[i] = 46'({$urandom(), $urandom()});
    @(posedge Clock);
    model_update();
    @(negedge Clock);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1; step(); Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Next = 1'b0; Auto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (RoutineRun !== 4'b0000) begin errors++; $display("FAIL reset_run got %b want 0000", RoutineRun); end
      checks++; if (RoutineTick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", RoutineTick); end
      checks++; if (OutputBus !== BLANK_PAT) begin errors++; $display("FAIL reset_out got %h want %h", OutputBus, BLANK_PAT); end
      checks++; if (Active !== 2'd0) begin errors++; $display("FAIL reset_active got %0d want 0", Active); end
    end
    Reset = 1'b0;
    step();
    checks++; if (RoutineRun !== 4'b0001) begin errors++; $display("FAIL reset_release_run got %b want 0001", RoutineRun); end
  endtask

  task automatic test_idle();
    int ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (RoutineTick === 1'b1) ticks++;
      checks++; if (OutputBus !== bus[0]) begin errors++; $display("FAIL idle_out got %h want %h", OutputBus, bus[0]); end
      checks++; if (RoutineTick !== m_tick) begin errors++; $display("FAIL idle_tick got %b want %b", RoutineTick, m_tick); end
      checks++; if (RoutineRun !== 4'b0001 || Active !== 2'd0) begin errors++; $display("FAIL idle_sel got run %b act %0d want 0001/0", RoutineRun, Active); end
    end
    checks++; if (ticks != 4) begin errors++; $display("FAIL idle_tick_count got %0d want 4", ticks); end
  endtask

  task automatic test_next_held();
    int nblank;
    int guard;
    Next = 1'b1; Auto = 1'b0; Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (Active !== 2'd0 || RoutineRun !== 4'b0001) begin errors++; $display("FAIL held_noadv got act %0d run %b want 0/0001", Active, RoutineRun); end
    end
    Next = 1'b0; step();
    Next = 1'b1; step();
    checks++; if (Active !== 2'd1 || RoutineRun !== 4'b0000) begin errors++; $display("FAIL press_adv got act %0d run %b want 1/0000", Active, RoutineRun); end
    Next = 1'b0; step();
    checks++; if (OutputBus !== BLANK_PAT) begin errors++; $display("FAIL press_blank got %h want %h", OutputBus, BLANK_PAT); end
    nblank = 2; guard = 0;
    while (RoutineRun === 4'b0000 && guard < 20) begin
      step(); guard++;
      if (RoutineRun === 4'b0000) nblank++;
      checks++; if (OutputBus !== m_out) begin errors++; $display("FAIL press_out got %h want %h", OutputBus, m_out); end
    end
    checks++; if (RoutineRun !== 4'b0010) begin errors++; $display("FAIL press_resume got %b want 0010", RoutineRun); end
    checks++; if (nblank < 5 || nblank > 8) begin errors++; $display("FAIL press_blank_len got %0d want 5..8", nblank); end
  endtask

  task automatic test_auto_cycle();
    logic [1:0] seq [0:3];
    logic [1:0] prev;
    int n = 0;
    Next = 1'b0; pulse_reset(); Auto = 1'b1;
    for (int i = 0; i < 200 && n < 4; i++) begin
      prev = Active;
      step();
      checks++; if (Active !== m_active || RoutineRun !== m_run) begin errors++; $display("FAIL auto_state got act %0d run %b want %0d/%b", Active, RoutineRun, m_active, m_run); end
      checks++; if (OutputBus !== m_out) begin errors++; $display("FAIL auto_out got %h want %h", OutputBus, m_out); end
      if (Active !== prev) begin seq[n] = Active; n++; end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL auto_timeout got %0d advances want 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== 2'(i + 1)) begin errors++; $display("FAIL auto_seq[%0d] got %0d want %0d", i, seq[i], (i + 1) % 4); end
    end
  endtask

  task automatic test_coincident();
    logic [1:0] a1;
    int guard = 0;
    Next = 1'b0; pulse_reset(); Auto = 1'b1;
    while (!(m_tick && !m_blanking && m_dwell_left == 1) && guard < 60) begin step(); guard++; end
    checks++; if (guard >= 60) begin errors++; $display("FAIL coin_timeout got %0d want <60", guard); end
    a1 = Active + 2'd1;
    Next = 1'b1; step();
    checks++; if (Active !== a1) begin errors++; $display("FAIL coin_adv got %0d want %0d", Active, a1); end
    guard = 0;
    while (RoutineRun === 4'b0000 && guard < 20) begin
      Next = ~Next; step(); guard++;
      checks++; if (Active !== a1) begin errors++; $display("FAIL blank_ignore got %0d want %0d", Active, a1); end
    end
    Next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (Active !== a1 || RoutineRun !== m_run) begin errors++; $display("FAIL coin_after got act %0d run %b want %0d/%b", Active, RoutineRun, a1, m_run); end
    end
  endtask

  task automatic test_auto_drop();
    int ticks = 0;
    int guard = 0;
    Next = 1'b0; pulse_reset(); Auto = 1'b1;
    while (ticks < 2 && guard < 30) begin
      if (RoutineTick === 1'b1) ticks++;
      step(); guard++;
    end
    Auto = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (Active !== 2'd0 || RoutineRun !== 4'b0001) begin errors++; $display("FAIL drop_hold got act %0d run %b want 0/0001", Active, RoutineRun); end
    end
    Auto = 1'b1; ticks = 0; guard = 0;
    while (Active === 2'd0 && guard < 40) begin
      if (RoutineTick === 1'b1) ticks++;
      step(); guard++;
    end
    checks++; if (Active !== 2'd1) begin errors++; $display("FAIL drop_adv got %0d want 1", Active); end
    checks++; if (ticks != 3) begin errors++; $display("FAIL drop_ticks got %0d want 3", ticks); end
  endtask

  task automatic test_reset_in_blank();
    int guard = 0;
    Auto = 1'b0; Next = 1'b0; pulse_reset(); step();
    Next = 1'b1; step(); Next = 1'b0;
    while (RoutineRun === 4'b0000 && guard < 20) begin step(); guard++; end
    Next = 1'b1; step(); Next = 1'b0;
    checks++; if (Active !== 2'd2 || RoutineRun !== 4'b0000) begin errors++; $display("FAIL rib_setup got act %0d run %b want 2/0000", Active, RoutineRun); end
    step(); step();
    Reset = 1'b1; step();
    checks++; if (Active !== 2'd0 || RoutineRun !== 4'b0000) begin errors++; $display("FAIL rib_reset got act %0d run %b want 0/0000", Active, RoutineRun); end
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (Active !== 2'd0 || RoutineRun !== 4'b0001) begin errors++; $display("FAIL rib_after got act %0d run %b want 0/0001", Active, RoutineRun); end
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 800; i++) begin
      Reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) Next = ~Next;
      if ($urandom_range(0, 39) == 0) Auto = ~Auto;
      step();
      checks++; if (Active !== m_active) begin errors++; $display("FAIL rand_active got %0d want %0d", Active, m_active); end
      checks++; if (RoutineRun !== m_run) begin errors++; $display("FAIL rand_run got %b want %b", RoutineRun, m_run); end
      checks++; if (RoutineTick !== m_tick) begin errors++; $display("FAIL rand_tick got %b want %b", RoutineTick, m_tick); end
      checks++; if (OutputBus !== m_out) begin errors++; $display("FAIL rand_out got %h want %h", OutputBus, m_out); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) bus[i] = 46'd0;
    test_reset();
    test_idle();
    test_next_held();
    test_auto_cycle();
    test_coincident();
    test_auto_drop();
    test_reset_in_blank();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
